// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings and memory-lane helpers.
// Byte-lane helpers are used by memory_cycle when MEMORY_CYCLE_BYTE_LANES_EN is set.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] f_byte_en(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'hF;
    case (f3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  // Replicating the narrow datum across lanes lets the byte
  // enables alone pick the destination.
  function automatic logic [XLEN-1:0] f_store_data(
    input logic [2:0]      f3,
    input logic [XLEN-1:0] d
  );
    logic [XLEN-1:0] w;
    w = d;
    case (f3)
      F3_B:    w = {4{d[7:0]}};
      F3_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [XLEN-1:0] f_load_fmt(
    input logic [2:0]      f3,
    input logic [1:0]      off,
    input logic [XLEN-1:0] word
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    r = word;
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'h0, b};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/memory_cycle_data_memory.sv
// Word-organised data memory with per-byte write enables.
// Combinational read; contents are not cleared by reset.
module data_memory
  import riscv_pkg::*;
#(
  parameter  int DMEM_DEPTH = 1024,
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [DMEM_AW-1:0] idx,
  input  logic [XLEN-1:0]    wdata,
  output logic [XLEN-1:0]    rdata
);

  logic [XLEN-1:0] r_mem [DMEM_DEPTH];

  // rst gates the write so a store in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (we && rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = r_mem[idx];

endmodule

// File: rtl/memory_cycle.sv
// RV32I memory stage: data-memory access and MEM/WB register.
// Optional byte/halfword access: define MEMORY_CYCLE_BYTE_LANES_EN.
module memory_cycle
  import riscv_pkg::*;
#(
  parameter int DMEM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic            ResultSrcM,
  input  logic [4:0]      RDM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] ALU_ResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic            RegWriteW,
  output logic            ResultSrcW,
  output logic [4:0]      RDW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW
);

  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  logic [DMEM_AW-1:0] w_idx;
  logic [3:0]         w_be;
  logic [XLEN-1:0]    w_wdata;
  logic [XLEN-1:0]    w_rword;
  logic [XLEN-1:0]    w_rdata;

  assign w_idx = ALU_ResultM[DMEM_AW+1:2];

`ifdef MEMORY_CYCLE_BYTE_LANES_EN
  assign w_be    = f_byte_en(Funct3M, ALU_ResultM[1:0]);
  assign w_wdata = f_store_data(Funct3M, WriteDataM);
  assign w_rdata = f_load_fmt(Funct3M, ALU_ResultM[1:0], w_rword);
`else
  logic w_unused_f3;
  assign w_unused_f3 = ^Funct3M;
  assign w_be        = 4'hF;
  assign w_wdata     = WriteDataM;
  assign w_rdata     = w_rword;
`endif

  data_memory #(
    .DMEM_DEPTH(DMEM_DEPTH)
  ) u_dmem (
    .clk  (clk),
    .rst  (rst),
    .we   (MemWriteM),
    .be   (w_be),
    .idx  (w_idx),
    .wdata(w_wdata),
    .rdata(w_rword)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RDW         <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else begin
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RDW         <= RDM;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= w_rdata;
    end
  end

endmodule
